// File: rtl/svc_uart_tx_arb_pkg.sv
// Shared types for the UART TX byte-stream arbiter.
package svc_uart_tx_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       last;
    logic [7:0] data;
  } tx_byte_t;

  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/svc_rr_pick.sv
// Combinational circular first-set finder: first req bit at or after ptr, wrapping.
module svc_rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          valid
);

  // Scan farthest-first so the candidate nearest ptr is written last and wins.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      int j;
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j[IW-1:0]]) begin
        grant = j[IW-1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/svc_uart_tx_arb.sv
// Message-granular round-robin arbiter in front of a single UART TX byte stream.
// Optional idle-owner timeout: define SVC_UART_TX_ARB_TIMEOUT_EN.
module svc_uart_tx_arb
  import svc_uart_tx_arb_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  parameter  int TIMEOUT = 1024,
  localparam int IW      = idx_w(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   s_valid,
  input  logic [NUM_REQ*8-1:0] s_data,
  input  logic [NUM_REQ-1:0]   s_last,
  output logic [NUM_REQ-1:0]   s_ready,
  output logic                 m_valid,
  output logic [7:0]           m_data,
  input  logic                 m_ready,
  output logic [IW-1:0]        grant_idx,
  output logic                 busy
);

  state_t                    state, state_nxt;
  logic [IW-1:0]             grant_nxt, rr_ptr, rr_nxt, pick_idx, g_inc;
  logic                      pick_vld, xfer_last, to_hit;
  logic [NUM_REQ-1:0][7:0]   data_arr;
  tx_byte_t                  own;

  assign data_arr  = s_data;
  assign own       = '{valid: s_valid[grant_idx], last: s_last[grant_idx],
                       data: data_arr[grant_idx]};
  assign g_inc     = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
  assign xfer_last = (state == LOCKED) && own.valid && m_ready && own.last;

  svc_rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req   (s_valid),
    .ptr   (rr_ptr),
    .grant (pick_idx),
    .valid (pick_vld)
  );

`ifdef SVC_UART_TX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt, to_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) to_cnt <= '0;
    else        to_cnt <= to_cnt_nxt;
  end

  // Counts consecutive stalled LOCKED cycles; any owner valid clears it.
  always_comb begin
    to_cnt_nxt = '0;
    to_hit     = 1'b0;
    if (state == LOCKED && !own.valid) begin
      if (to_cnt == TW'(TIMEOUT - 1)) to_hit     = 1'b1;
      else                            to_cnt_nxt = to_cnt + TW'(1);
    end
  end
`else
  // Without the counter TIMEOUT has no effect; this is constant 0 for any legal value.
  assign to_hit = (TIMEOUT < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant_idx <= '0;
      rr_ptr    <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant_idx <= grant_nxt;
      rr_ptr    <= rr_nxt;
      busy      <= (state_nxt == LOCKED);
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_idx;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_nxt = pick_idx;
          state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (xfer_last || to_hit) begin
          state_nxt = IDLE;
          rr_nxt    = g_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Owner passes through combinationally; everyone else sees ready low.
  always_comb begin
    m_valid = 1'b0;
    m_data  = '0;
    s_ready = '0;
    if (state == LOCKED) begin
      m_valid            = own.valid;
      m_data             = own.data;
      s_ready[grant_idx] = m_ready;
    end
  end

endmodule

// File: tb/tb_svc_uart_tx_arb.sv
// Directed bench for svc_uart_tx_arb (NUM_REQ=2, TIMEOUT=8).
module tb_svc_uart_tx_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  s_valid, s_last, s_ready;
  logic [15:0] s_data;
  logic        m_valid, m_ready, busy;
  logic [7:0]  m_data;
  logic [0:0]  grant_idx;
  int          total = 0, passed = 0, failed = 0;

  always #5 clk = ~clk;

  svc_uart_tx_arb #(.NUM_REQ(2), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
    .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .grant_idx(grant_idx), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] v, input logic [7:0] d1, input logic [7:0] d0,
                     input logic [1:0] l);
    s_valid = v;
    s_data  = {d1, d0};
    s_last  = l;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; m_ready = 1'b1;
    drv(2'b00, 8'h00, 8'h00, 2'b00);
    #2;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy",    busy,    0);
    chk("rst_m_data",  m_data,  0);
    chk("rst_grant",   grant_idx, 0);
    tick(); tick();
    rst_n = 1'b1;

    // basic "HI" from req0
    drv(2'b01, 8'h00, 8'h48, 2'b00);
    chk("hi_idle_mv", m_valid, 0);
    chk("hi_idle_rdy", s_ready, 0);
    tick(); drv(2'b01, 8'h00, 8'h48, 2'b00);
    chk("hi_mv", m_valid, 1);
    chk("hi_H", m_data, 8'h48);
    chk("hi_rdy", s_ready, 2'b01);
    chk("hi_busy", busy, 1);
    tick(); drv(2'b01, 8'h00, 8'h49, 2'b01);
    chk("hi_I", m_data, 8'h49);
    tick(); drv(2'b00, 8'h00, 8'h00, 2'b00);
    chk("hi_done_busy", busy, 0);
    chk("hi_done_mv", m_valid, 0);

    // simultaneous 3-byte messages from reset
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    drv(2'b11, 8'hB0, 8'hA0, 2'b00);
    tick(); drv(2'b11, 8'hB0, 8'hA0, 2'b00);
    chk("sim_g0", grant_idx, 0);
    chk("sim_A0", m_data, 8'hA0);
    chk("sim_rdy0", s_ready, 2'b01);
    tick(); drv(2'b11, 8'hB0, 8'hA1, 2'b00);
    chk("sim_A1", m_data, 8'hA1);
    chk("sim_rdy1", s_ready, 2'b01);
    tick(); drv(2'b11, 8'hB0, 8'hA2, 2'b01);
    chk("sim_A2", m_data, 8'hA2);
    tick(); drv(2'b10, 8'hB0, 8'h00, 2'b00);
    chk("sim_bub_mv", m_valid, 0);
    chk("sim_bub_rdy", s_ready, 0);
    chk("sim_bub_busy", busy, 0);
    tick(); drv(2'b10, 8'hB0, 8'h00, 2'b00);
    chk("sim_g1", grant_idx, 1);
    chk("sim_B0", m_data, 8'hB0);
    chk("sim_rdyB", s_ready, 2'b10);
    tick(); drv(2'b10, 8'hB1, 8'h00, 2'b00);
    chk("sim_B1", m_data, 8'hB1);
    tick(); drv(2'b10, 8'hB2, 8'h00, 2'b10);
    chk("sim_B2", m_data, 8'hB2);
    tick(); drv(2'b00, 8'h00, 8'h00, 2'b00);
    chk("sim_end_busy", busy, 0);

    // fairness: req1 back-to-back, req0 waits then wins
    drv(2'b10, 8'hC0, 8'h00, 2'b00);
    tick(); drv(2'b11, 8'hC0, 8'hD0, 2'b01);
    chk("fair_g1", grant_idx, 1);
    chk("fair_C0", m_data, 8'hC0);
    chk("fair_rdy", s_ready, 2'b10);
    tick(); drv(2'b11, 8'hC1, 8'hD0, 2'b11);
    chk("fair_C1", m_data, 8'hC1);
    chk("fair_rdy2", s_ready, 2'b10);
    tick(); drv(2'b11, 8'hC2, 8'hD0, 2'b11);
    chk("fair_bub", m_valid, 0);
    tick(); drv(2'b11, 8'hC2, 8'hD0, 2'b11);
    chk("fair_g0", grant_idx, 0);
    chk("fair_D0", m_data, 8'hD0);
    chk("fair_rdyD", s_ready, 2'b01);
    tick(); drv(2'b10, 8'hC2, 8'h00, 2'b10);
    chk("fair_bub2", busy, 0);
    tick(); drv(2'b10, 8'hC2, 8'h00, 2'b10);
    chk("fair_g1b", grant_idx, 1);
    chk("fair_C2", m_data, 8'hC2);
    tick(); drv(2'b00, 8'h00, 8'h00, 2'b00);

    // backpressure on a 4-byte req0 message, req1 waiting
    m_ready = 1'b0;
    drv(2'b11, 8'hF0, 8'hE0, 2'b10);
    tick(); drv(2'b11, 8'hF0, 8'hE0, 2'b10);
    chk("bp_mv", m_valid, 1);
    chk("bp_E0a", m_data, 8'hE0);
    chk("bp_rdy_lo0", s_ready, 2'b00);
    tick(); m_ready = 1'b1; drv(2'b11, 8'hF0, 8'hE0, 2'b10);
    chk("bp_E0b", m_data, 8'hE0);
    chk("bp_rdy_hi0", s_ready, 2'b01);
    tick(); m_ready = 1'b0; drv(2'b11, 8'hF0, 8'hE1, 2'b10);
    chk("bp_E1a", m_data, 8'hE1);
    chk("bp_rdy_lo1", s_ready, 2'b00);
    tick(); m_ready = 1'b1; drv(2'b11, 8'hF0, 8'hE1, 2'b10);
    chk("bp_E1b", m_data, 8'hE1);
    chk("bp_rdy_hi1", s_ready, 2'b01);
    tick(); m_ready = 1'b0; drv(2'b11, 8'hF0, 8'hE2, 2'b10);
    chk("bp_E2a", m_data, 8'hE2);
    tick(); m_ready = 1'b1; drv(2'b11, 8'hF0, 8'hE2, 2'b10);
    chk("bp_E2b", m_data, 8'hE2);
    chk("bp_rdy_hi2", s_ready, 2'b01);
    tick(); m_ready = 1'b0; drv(2'b11, 8'hF0, 8'hE3, 2'b11);
    chk("bp_E3a", m_data, 8'hE3);
    chk("bp_busy_hold", busy, 1);
    tick(); m_ready = 1'b1; drv(2'b11, 8'hF0, 8'hE3, 2'b11);
    chk("bp_E3b", m_data, 8'hE3);
    chk("bp_rdy_hi3", s_ready, 2'b01);
    tick(); drv(2'b10, 8'hF0, 8'h00, 2'b10);
    chk("bp_end_busy", busy, 0);
    tick(); drv(2'b10, 8'hF0, 8'h00, 2'b10);
    chk("bp_F0", m_data, 8'hF0);
    chk("bp_g1", grant_idx, 1);
    tick(); drv(2'b00, 8'h00, 8'h00, 2'b00);

    // reset mid-message: req0 one-byte lock, then req1 interrupted
    drv(2'b01, 8'h00, 8'h47, 2'b01);
    tick(); drv(2'b01, 8'h00, 8'h47, 2'b01);
    chk("one_byte", m_data, 8'h47);
    tick(); drv(2'b10, 8'h30, 8'h00, 2'b00);
    tick(); drv(2'b10, 8'h30, 8'h00, 2'b00);
    chk("rm_H0", m_data, 8'h30);
    chk("rm_g1", grant_idx, 1);
    tick(); drv(2'b10, 8'h31, 8'h00, 2'b00);
    tick(); drv(2'b10, 8'h32, 8'h00, 2'b00);
    chk("rm_H2", m_data, 8'h32);
    chk("rm_mv", m_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("rm_async_mv", m_valid, 0);
    chk("rm_async_rdy", s_ready, 0);
    chk("rm_async_busy", busy, 0);
    tick(); drv(2'b11, 8'h33, 8'h55, 2'b01);
    rst_n = 1'b1;
    #1;
    chk("rm_idle_mv", m_valid, 0);
    tick(); drv(2'b11, 8'h33, 8'h55, 2'b01);
    chk("rm_g0", grant_idx, 0);
    chk("rm_55", m_data, 8'h55);
    tick(); drv(2'b00, 8'h00, 8'h00, 2'b00);
    tick();

`ifdef SVC_UART_TX_ARB_TIMEOUT_EN
    drv(2'b01, 8'h00, 8'h77, 2'b00);
    tick(); drv(2'b01, 8'h00, 8'h77, 2'b00);
    chk("to_77", m_data, 8'h77);
    tick(); drv(2'b10, 8'h78, 8'h00, 2'b10);
    for (int i = 0; i < 8; i++) begin
      chk("to_hold_busy", busy, 1);
      tick();
    end
    chk("to_release", busy, 0);
    tick();
    chk("to_g1", grant_idx, 1);
    chk("to_78", m_data, 8'h78);
    drv(2'b00, 8'h00, 8'h00, 2'b00);
    tick(); tick();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/svc_uart_tx_arb.md
# svc_uart_tx_arb

Round-robin, message-granular arbiter that shares one UART transmitter byte stream between `NUM_REQ` requesters, such as the RISC-V console and a status/ebreak reporter. It sits between the requesters' valid/ready byte streams and the single `svc_uart_tx` input. A requester holds the grant from its first byte until it transfers a byte with `s_last` set, so messages from different requesters never interleave.

## Interface
- `NUM_REQ`, default 2: number of requesters; legal range is 2 to 8.
- `TIMEOUT`, default 1024: number of idle cycles a locked requester may stall before losing the grant. Only used when `SVC_UART_TX_ARB_TIMEOUT_EN` is defined.
- `clk` input, 1 bit: the single clock.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `s_valid` input, `NUM_REQ` bits: per-requester byte valid.
- `s_data` input, `NUM_REQ`*8 bits: requester i's byte is at bits [8i+7:8i].
- `s_last` input, `NUM_REQ` bits: marks the final byte of a message.
- `s_ready` output, `NUM_REQ` bits: per-requester ready.
- `m_valid` output, 1 bit: byte valid toward the UART.
- `m_data` output, 8 bits: byte toward the UART.
- `m_ready` input, 1 bit: UART ready.
- `grant_idx` output, `IW` bits: index of the current owner, where `IW` = max(1, $clog2(`NUM_REQ`)).
- `busy` output, 1 bit: high while in `LOCKED`.

## Operation
- FSM states are `IDLE` and `LOCKED`. Registers are `state`, `grant_idx`, `rr_ptr` (`IW` bits), and the optional `to_cnt`.
- **IDLE**
  - `m_valid`=0 and all `s_ready`=0.
  - If any `s_valid` is high, pick the first set bit scanning circularly from `rr_ptr` (`rr_ptr`, `rr_ptr`+1 … wrapping at `NUM_REQ`-1 to 0).
  - Register the pick into `grant_idx`, then go to `LOCKED`.
- **LOCKED**
  - The owner's signals pass through combinationally: `m_valid`=`s_valid[g]`, `m_data`=`s_data[g]`, `s_ready[g]`=`m_ready`.
  - All other `s_ready` bits are 0.
  - When `m_valid`&&`m_ready`&&`s_last[g]`: go to `IDLE` and set `rr_ptr`=(g+1) mod `NUM_REQ`.
- **Grant stability:** `grant_idx` changes only in `IDLE`. Requesters that assert valid while another owns the grant wait, and never see `s_ready`.
- **Requester rules:**
  - A requester must not drop `s_valid` or change `s_data`/`s_last` while valid is high and ready is low.
  - The arbiter does not check this.
- **Single-byte message:** `s_last` high on the first byte is legal. That is a one-byte lock.
- **Owner deasserts `s_valid` mid-message:** the arbiter stays `LOCKED`, except for a timeout (see Configuration).
- **Reset values:** `state`=`IDLE`, `grant_idx`=0, `rr_ptr`=0, `to_cnt`=0. So `m_valid`=0, `s_ready`=0, `busy`=0, `m_data`=0.
- **Reset mid-message:** asserting `rst_n` low drops `m_valid` immediately (asynchronously). The partial message is abandoned.

## Timing
- Arbitration latency is 1 cycle. A valid seen in `IDLE` at cycle N gives a grant in cycle N+1, and the first byte can transfer in cycle N+1.
- Inside a message the arbiter is zero-latency and full throughput: one byte per cycle when `m_ready` is held high.
- Each message boundary costs exactly one bubble cycle (`IDLE`), including when the same requester follows itself.
- `busy` is registered and equals (`state`==`LOCKED`).

## Configuration
- Macro: `SVC_UART_TX_ARB_TIMEOUT_EN`.
- **Defined:**
  - `to_cnt` is `$clog2(TIMEOUT+1)` bits wide and increments each `LOCKED` cycle with `s_valid[g]`=0.
  - It clears on `IDLE` and on any `LOCKED` cycle with `s_valid[g]`=1.
  - When `to_cnt` reaches `TIMEOUT`-1 with `s_valid[g]` still 0, the grant is forcibly released: `IDLE` next cycle, `rr_ptr`=g+1.
  - A cycle with `s_valid[g]`=1 never times out.
- **Undefined:** no counter; the lock is held indefinitely.

## Structure
- Package `svc_uart_tx_arb_pkg` holds the `state_t` enum (`IDLE`, `LOCKED`).
- Sub-module `svc_rr_pick` is a combinational circular first-set finder with ports `req[N]`, `ptr`, `grant`, `valid`. It is reusable by other arbiters.

## Test plan
- **Basic transfer:** req0 sends "HI" (`s_last` on 'I') with `m_ready`=1. Expect `m_data` 0x48 then 0x49 on consecutive cycles after the 1-cycle grant, then `busy`=0.
- **Simultaneous requests:** req0 and req1 both start a 3-byte message at once from reset. Expect all 3 bytes from req0, 1 bubble, then all 3 from req1, with no interleave. Then `rr_ptr`=0.
- **Fairness:** req1 sends back-to-back messages while req0 waits. Expect req0 to get the grant after req1's first message.
- **Backpressure:** toggle `m_ready` 1/0 each cycle during a 4-byte message. Expect the bytes in order, no byte lost or duplicated, and `s_ready` to mirror `m_ready` for the owner only.
- **Timeout** (`SVC_UART_TX_ARB_TIMEOUT_EN`, `TIMEOUT`=8): req0 sends 1 non-last byte, then holds valid low. Expect `busy` to fall 8 cycles later and req1 to be granted next.
- **Reset mid-message:** pulse `rst_n` low during byte 2 of 5. Expect `m_valid`=0 immediately. After release, a new request is served from index 0.
